// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the I/O-window responder: register selects and
// the bit layout of the status register.
package mmio_responder_pkg;

  typedef enum logic [2:0] {
    SEL_DATA = 3'd0,
    SEL_STAT = 3'd1,
    SEL_CNT0 = 3'd2,
    SEL_CNT1 = 3'd3,
    SEL_CNT2 = 3'd4,
    SEL_CNT3 = 3'd5,
    SEL_HALT = 3'd6,
    SEL_ZERO = 3'd7
  } sel_e;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_RX_NONEMPTY = 1;
  localparam int ST_OVERFLOW    = 2;

endpackage

// File: rtl/mmio_responder_byte_fifo.sv
// Small synchronous FIFO with extra-MSB wrap pointers. A push into a full
// FIFO is still taken when a pop happens in the same cycle; callers that
// must refuse in that case gate push with ~full themselves.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer registers; reset empties the FIFO.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: storage has no reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_responder.sv
// Byte-bus responder for the CPU I/O window: console TX/RX FIFOs, a
// free-running cycle counter with a readable snapshot, and a halt flag.
// Read data is registered, giving the same one-cycle latency as RAM.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rdy_in,
  input  logic       en_in,
  input  logic       wr_in,
  input  logic [2:0] a_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       halt_out
);

  sel_e        sel;
  logic        active;
  logic        wr_acc;
  logic        rd_acc;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_head;
  logic        ovf_set;
  logic        overflow;
  logic [31:0] counter;
  logic [31:8] snap_hi;   // low byte of the snapshot is never readable
  logic [7:0]  d_next;

  assign sel    = sel_e'(a_in);
  assign active = en_in & rdy_in;
  assign wr_acc = active & wr_in;
  assign rd_acc = active & ~wr_in;

  assign tx_push  = wr_acc && (sel == SEL_DATA);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = ~tx_empty;
  // A pop in the same cycle frees the slot, so only a pop-less full push drops.
  assign ovf_set  = tx_push & tx_full & ~tx_pop;

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_acc && (sel == SEL_DATA) && !rx_empty;

  byte_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (d_in),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Read-data mux; without a read access d_out keeps its value.
  // NOTE: d_next gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    d_next = d_out;
    if (rd_acc) begin
      d_next = 8'h00;
      case (sel)
        SEL_DATA: if (!rx_empty) d_next = rx_head;
        SEL_STAT: begin
          d_next[ST_OVERFLOW]    = overflow;
          d_next[ST_RX_NONEMPTY] = ~rx_empty;
          d_next[ST_TX_FULL]     = tx_full;
        end
        SEL_CNT0: d_next = counter[7:0];
        SEL_CNT1: d_next = snap_hi[15:8];
        SEL_CNT2: d_next = snap_hi[23:16];
        SEL_CNT3: d_next = snap_hi[31:24];
        default:  d_next = 8'h00;
      endcase
    end
  end

  // Read data, counter, snapshot, sticky overflow and halt flag.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      d_out    <= 8'h00;
      counter  <= '0;
      snap_hi  <= '0;
      overflow <= 1'b0;
      halt_out <= 1'b0;
    end else begin
      d_out <= d_next;
      if (rdy_in) counter <= counter + 32'd1;
      if (rd_acc && (sel == SEL_CNT0)) snap_hi <= counter[31:8];
      // A same-cycle overflow beats the clear-on-read.
      if (ovf_set)                          overflow <= 1'b1;
      else if (rd_acc && (sel == SEL_STAT)) overflow <= 1'b0;
      if (wr_acc && (sel == SEL_HALT)) halt_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios followed by a
// random phase, checked against a queue-based reference model. Expected
// read data and transmitted bytes go into scoreboards that a negedge
// monitor drains and compares.
module tb_mmio_responder;

  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       rdy_in = 1'b0;
  logic       en_in = 1'b0;
  logic       wr_in = 1'b0;
  logic [2:0] a_in = 3'd0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       halt_out;

  mmio_responder #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk_in   (clk),
    .rst_in_n (rst_in_n),
    .rdy_in   (rdy_in),
    .en_in    (en_in),
    .wr_in    (wr_in),
    .a_in     (a_in),
    .d_in     (d_in),
    .d_out    (d_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .halt_out (halt_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0]  tx_sb[$];   // bytes expected on the TX side, in order
  int          tx_cnt;     // TX occupancy as seen by the model
  logic [7:0]  rx_q[$];    // RX FIFO contents
  logic [7:0]  rd_sb[$];   // expected d_out after each clock
  bit          m_ovf;
  bit          m_halt;
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic [7:0]  m_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares d_out every cycle and each TX handshake.
  always @(negedge clk) begin
    if (rd_sb.size() > 0) check("d_out", {24'b0, d_out}, {24'b0, rd_sb.pop_front()});
    if (rst_in_n && tx_valid && tx_ready) begin
      if (tx_sb.size() == 0) check("tx_unexpected", {31'b0, tx_valid}, 32'd0);
      else                   check("tx_data", {24'b0, tx_data}, {24'b0, tx_sb.pop_front()});
    end
  end

  task automatic model_clear();
    tx_sb.delete();
    rx_q.delete();
    rd_sb.delete();
    tx_cnt = 0;
    m_ovf  = 0;
    m_halt = 0;
    m_cnt  = 0;
    m_snap = 0;
    m_dout = 8'h00;
  endtask

  task automatic idle_inputs();
    rdy_in = 0; en_in = 0; wr_in = 0; a_in = 0; d_in = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_out"},    {24'b0, d_out}, 32'd0);
    check({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
    check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd1);
    check({tag, "_halt"},     {31'b0, halt_out}, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    rst_in_n = 0;
    model_clear();
    @(posedge clk); @(posedge clk);
    #2 rst_in_n = 1;
    @(posedge clk); #1;
  endtask

  // One bus cycle: drive inputs, check flags, predict, clock, record.
  task automatic step(input bit rdy, input bit en, input bit wr, input logic [2:0] a,
                      input logic [7:0] d, input bit txr, input bit rxv, input logic [7:0] rxd);
    bit         active, tx_pop, tx_acc, ovf_set, rx_acc;
    logic [7:0] rxb;
    rdy_in = rdy; en_in = en; wr_in = wr; a_in = a; d_in = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    check("tx_valid", {31'b0, tx_valid}, {31'b0, tx_cnt != 0});
    check("rx_ready", {31'b0, rx_ready}, {31'b0, rx_q.size() < RX_DEPTH});
    check("halt_out", {31'b0, halt_out}, {31'b0, m_halt});

    active  = rdy && en;
    tx_pop  = txr && (tx_cnt > 0);
    tx_acc  = 0;
    ovf_set = 0;
    if (active && wr && a == 3'd0) begin
      if (tx_cnt < TX_DEPTH || tx_pop) tx_acc = 1;
      else                             ovf_set = 1;
    end
    rx_acc = rxv && (rx_q.size() < RX_DEPTH);
    rxb = rxd;

    if (active && !wr) begin
      case (a)
        3'd0: m_dout = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        3'd1: begin
          m_dout = {5'b0, m_ovf, rx_q.size() > 0, tx_cnt == TX_DEPTH};
          m_ovf  = 0;
        end
        3'd2: begin m_dout = m_cnt[7:0]; m_snap = m_cnt; end
        3'd3: m_dout = m_snap[15:8];
        3'd4: m_dout = m_snap[23:16];
        3'd5: m_dout = m_snap[31:24];
        default: m_dout = 8'h00;
      endcase
    end
    if (ovf_set) m_ovf = 1;
    if (active && wr && a == 3'd6) m_halt = 1;
    if (rx_acc) rx_q.push_back(rxb);
    tx_cnt = tx_cnt - int'(tx_pop) + int'(tx_acc);

    @(posedge clk);
    if (rdy) m_cnt = m_cnt + 1;
    if (tx_acc) tx_sb.push_back(d);
    rd_sb.push_back(m_dout);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d, input bit txr);
    step(1, 1, 1, a, d, txr, 0, 8'h00);
  endtask

  task automatic rd_reg(input logic [2:0] a, input bit txr);
    step(1, 1, 0, a, 8'h00, txr, 0, 8'h00);
  endtask

  task automatic nop(input bit txr);
    step(1, 0, 0, 3'd0, 8'h00, txr, 0, 8'h00);
  endtask

  logic [7:0] v1;

  initial begin
    model_clear();
    #2;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    do_reset();
    check_reset_outputs("rst1");

    // Status after reset, single TX byte and its drain.
    rd_reg(3'd1, 0);
    check("stat_reset", {24'b0, d_out}, 32'h00);
    wr_reg(3'd0, 8'h41, 0);
    check("tx_head_41", {24'b0, tx_data}, 32'h41);
    nop(1);
    nop(0);

    // Overfill TX by one byte; overflow is sticky until read.
    for (int i = 0; i < 17; i++) wr_reg(3'd0, 8'(i), 0);
    rd_reg(3'd1, 0);
    check("stat_ovf", {24'b0, d_out}, 32'h05);
    rd_reg(3'd1, 0);
    check("stat_clr", {24'b0, d_out}, 32'h01);
    for (int i = 0; i < 17; i++) nop(1);

    // Two RX bytes, three reads: last read of the empty FIFO gives 0.
    step(1, 0, 0, 3'd0, 8'h00, 0, 1, 8'h55);
    step(1, 0, 0, 3'd0, 8'h00, 0, 1, 8'hAA);
    for (int i = 0; i < 3; i++) rd_reg(3'd0, 0);
    rd_reg(3'd1, 0);
    check("stat_rx_empty", {31'b0, d_out[1]}, 32'd0);

    // Fill RX, then read with a refused incoming byte.
    for (int i = 0; i < RX_DEPTH; i++) step(1, 0, 0, 3'd0, 8'h00, 0, 1, 8'(8'h10 + i));
    check("rx_full", {31'b0, rx_ready}, 32'd0);
    step(1, 1, 0, 3'd0, 8'h00, 0, 1, 8'h99);
    check("rx_pop_head", {24'b0, d_out}, 32'h10);
    check("rx_after_pop", {31'b0, rx_ready}, 32'd1);
    for (int i = 0; i < RX_DEPTH; i++) rd_reg(3'd0, 0);

    // Counter freezes while rdy_in is low; snapshot bytes follow.
    rd_reg(3'd2, 0);
    v1 = d_out;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 3'd2, 8'h00, 0, 0, 8'h00);
    rd_reg(3'd2, 0);
    check("cnt_freeze", {24'b0, d_out}, {24'b0, v1 + 8'd1});
    rd_reg(3'd3, 0);
    rd_reg(3'd4, 0);
    rd_reg(3'd5, 0);
    rd_reg(3'd7, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit         rdy, en, wr, txr, rxv;
      logic [2:0] a;
      rdy = ($urandom_range(0, 7) != 0);
      en  = $urandom_range(0, 1) == 1;
      wr  = $urandom_range(0, 1) == 1;
      a   = 3'($urandom_range(0, 7));
      if (wr && $urandom_range(0, 1) == 1) a = 3'd0;
      if (!wr && a == 3'd6) a = 3'd7;
      txr = $urandom_range(0, 3) == 0;
      rxv = $urandom_range(0, 2) == 0;
      step(rdy, en, wr, a, 8'($urandom), txr, rxv, 8'($urandom));
    end

    // Halt, then an asynchronous reset mid-cycle with data buffered.
    wr_reg(3'd0, 8'h77, 0);
    step(1, 0, 0, 3'd0, 8'h00, 0, 1, 8'h66);
    wr_reg(3'd6, 8'h01, 0);
    check("halt_set", {31'b0, halt_out}, 32'd1);
    #2;
    rst_in_n = 0;
    #1;
    check_reset_outputs("async");
    idle_inputs();
    model_clear();
    @(posedge clk);
    #2 rst_in_n = 1;
    @(posedge clk); #1;
    rd_reg(3'd1, 0);
    check("stat_post_rst", {24'b0, d_out}, 32'h00);
    nop(0);
    nop(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
